puf_nb_eval: RTL and testbench

PUF_NB_EVAL -- requirements
Module: puf_nb_eval

---
 rtl/puf_nb_eval_if.sv | 27 ++
 rtl/puf_nb_eval.sv | 195 +++++++++++++++++++
 tb/tb_puf_nb_eval.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/puf_nb_eval_if.sv
// Handshake and result bundle between a requester and the arbiter-PUF evaluator.
interface puf_nb_eval_if #(
    parameter int unsigned N_STAGES = 16,
    parameter int unsigned N_REPS   = 5
);
    localparam int unsigned CW = $clog2(N_REPS + 1);

    logic                start;
    logic [N_STAGES-1:0] Challenge;
    logic                arb_force_en;
    logic                arb_force_val;
    logic                busy;
    logic                done;
    logic                Response;
    logic [CW-1:0]       ones_count;
    logic                stable;

    modport master (
        output start, Challenge, arb_force_en, arb_force_val,
        input  busy, done, Response, ones_count, stable
    );

    modport slave (
        input  start, Challenge, arb_force_en, arb_force_val,
        output busy, done, Response, ones_count, stable
    );
endinterface

// File: rtl/puf_nb_eval.sv
// Arbiter PUF evaluator: races launch through a challenge-steered switch chain
// N_REPS times and majority-votes the synchronised arbiter samples.
module puf_nb_eval #(
    parameter int unsigned N_STAGES = 16,
    parameter int unsigned N_REPS   = 5,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned HOLD     = 4
) (
    input  logic clk,
    input  logic rst,
    puf_nb_eval_if.slave pif
);
    localparam int unsigned CW   = $clog2(N_REPS + 1);
    localparam int unsigned TMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam int unsigned RW   = (N_REPS > 1) ? $clog2(N_REPS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_FIRE = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [N_STAGES-1:0] challenge_r;
    logic [N_STAGES-1:0] chain_sel_r;
    logic [TW-1:0]       cnt_r, cnt_s;
    logic [RW-1:0]       rep_r, rep_s;
    logic [CW-1:0]       acc_r, acc_s;
    logic                finish_s;
    logic                sample_s;
    logic                launch_r;
    logic                busy_r;
    logic                done_r;
    logic                response_r;
    logic [CW-1:0]       ones_r;
    logic                stable_r;
    logic                sync1_r;
    logic                sync2_r;

    // Delay chain: both race paths start from launch; each stage straight or crossed.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        logic top_s;
        logic bot_s;
        if (i == 0) begin : g_first
            (* dont_touch = "true" *) switch_block u_sb (
                .in_top  (launch_r),
                .in_bot  (launch_r),
                .sel     (chain_sel_r[i]),
                .out_top (top_s),
                .out_bot (bot_s)
            );
        end else begin : g_next
            (* dont_touch = "true" *) switch_block u_sb (
                .in_top  (g_stage[i-1].top_s),
                .in_bot  (g_stage[i-1].bot_s),
                .sel     (chain_sel_r[i]),
                .out_top (top_s),
                .out_bot (bot_s)
            );
        end
    end

    (* dont_touch = "true" *) logic arb_q;

    // Arbiter: captures which path won the race, clocked by the top path.
    always_ff @(posedge g_stage[N_STAGES-1].top_s) begin
        arb_q <= g_stage[N_STAGES-1].bot_s;
    end

    // Two-flop synchroniser bringing the arbiter decision into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= arb_q;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = pif.arb_force_en ? pif.arb_force_val : sync2_r;

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rep_s    = rep_r;
        acc_s    = acc_r;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pif.start) begin
                    state_s = ST_LOAD;
                    cnt_s   = {TW{1'b0}};
                    rep_s   = {RW{1'b0}};
                    acc_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_ARM;
                cnt_s   = {TW{1'b0}};
            end
            ST_ARM: begin
                if (cnt_r == TW'(SETTLE - 1)) begin
                    state_s = ST_FIRE;
                    cnt_s   = {TW{1'b0}};
                end else begin
                    cnt_s = cnt_r + TW'(1);
                end
            end
            ST_FIRE: begin
                if (cnt_r == TW'(HOLD - 1)) begin
                    cnt_s = {TW{1'b0}};
                    // Bounded by N_REPS, which always fits CW bits.
                    acc_s = acc_r + CW'(sample_s);
                    if (rep_r == RW'(N_REPS - 1)) begin
                        state_s  = ST_DONE;
                        finish_s = 1'b1;
                    end else begin
                        rep_s   = rep_r + RW'(1);
                        state_s = ST_ARM;
                    end
                end else begin
                    cnt_s = cnt_r + TW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; results land as DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            challenge_r <= {N_STAGES{1'b0}};
            chain_sel_r <= {N_STAGES{1'b0}};
            cnt_r       <= {TW{1'b0}};
            rep_r       <= {RW{1'b0}};
            acc_r       <= {CW{1'b0}};
            launch_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            response_r  <= 1'b0;
            ones_r      <= {CW{1'b0}};
            stable_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rep_r    <= rep_s;
            acc_r    <= acc_s;
            launch_r <= (state_s == ST_FIRE);
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= finish_s;
            if ((state_r == ST_IDLE) && pif.start) begin
                challenge_r <= pif.Challenge;
            end
            if (state_r == ST_LOAD) begin
                chain_sel_r <= challenge_r;
            end
            if (finish_s) begin
                ones_r     <= acc_s;
                response_r <= (acc_s > CW'(N_REPS / 2));
                stable_r   <= (acc_s == {CW{1'b0}}) || (acc_s == CW'(N_REPS));
            end
        end
    end

    assign pif.busy       = busy_r;
    assign pif.done       = done_r;
    assign pif.Response   = response_r;
    assign pif.ones_count = ones_r;
    assign pif.stable     = stable_r;
endmodule

// One delay-chain stage: passes the two race paths straight or crossed.
module switch_block (
    input  logic in_top,
    input  logic in_bot,
    input  logic sel,
    output logic out_top,
    output logic out_bot
);
    assign out_top = sel ? in_bot : in_top;
    assign out_bot = sel ? in_top : in_bot;
endmodule

// File: tb/tb_puf_nb_eval.sv
// Scoreboard bench for puf_nb_eval: directed evaluations with forced arbiter bits.
module tb_puf_nb_eval;
    localparam int unsigned NS = 16;
    localparam int unsigned NR = 5;

    typedef struct {
        logic       resp;
        logic [2:0] ones;
        logic       stab;
        int         due;
        logic       loose;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic       hold_resp = 1'b0;
    logic [2:0] hold_ones = 3'd0;
    logic       hold_stab = 1'b0;

    always #5 clk = ~clk;

    puf_nb_eval_if #(.N_STAGES(NS), .N_REPS(NR)) bus ();

    puf_nb_eval #(.N_STAGES(NS), .N_REPS(NR), .SETTLE(4), .HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .pif (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done, otherwise checks results hold.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        cyc++;
        if (rst) begin
            hold_resp = 1'b0;
            hold_ones = 3'd0;
            hold_stab = 1'b0;
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.due);
                if (e.loose) begin
                    check("ones_le_reps", {31'd0, bus.ones_count <= 3'd5}, 32'd1);
                    check("resp_consistent", bus.Response, bus.ones_count > 3'd2);
                    check("stable_consistent", bus.stable,
                          (bus.ones_count == 3'd0) || (bus.ones_count == 3'd5));
                    hold_resp = bus.Response;
                    hold_ones = bus.ones_count;
                    hold_stab = bus.stable;
                end else begin
                    check("response", bus.Response, e.resp);
                    check("ones_count", bus.ones_count, e.ones);
                    check("stable", bus.stable, e.stab);
                    hold_resp = e.resp;
                    hold_ones = e.ones;
                    hold_stab = e.stab;
                end
            end
        end else begin
            check("results_hold", {bus.Response, bus.ones_count, bus.stable},
                  {hold_resp, hold_ones, hold_stab});
        end
    end

    // One evaluation; pat[r] is the forced bit for rep r.
    task automatic run_eval(input logic [15:0] ch, input logic [15:0] ch_after,
                            input logic [4:0] pat, input logic fen,
                            input logic er, input logic [2:0] eo, input logic es,
                            input int extra_c, input int abort_c, input logic done_start);
        exp_t e;
        @(negedge clk);
        bus.Challenge     = ch;
        bus.start         = 1'b1;
        bus.arb_force_en  = fen;
        bus.arb_force_val = pat[0];
        e.resp  = er;
        e.ones  = eo;
        e.stab  = es;
        e.due   = cyc + 42;
        e.loose = !fen;
        exp_q.push_back(e);
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            bus.start = (c == extra_c) || ((c == 42) && done_start);
            if (c == 1) begin
                check("busy_after_accept", bus.busy, 1'b1);
                bus.Challenge = ch_after;
            end
            if (c >= 2 && c <= 41) begin
                bus.arb_force_val = pat[(c - 2) / 8];
                check("launch", dut.launch_r, ((c - 2) % 8) >= 4);
                check("chain_sel", dut.chain_sel_r, ch);
            end
            if (c == abort_c) begin
                rst = 1'b1;
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                check("abort_outputs",
                      {bus.busy, bus.done, bus.Response, bus.ones_count, bus.stable, dut.launch_r},
                      8'd0);
                return;
            end
            if (c == 42) begin
                check("busy_in_done", bus.busy, 1'b1);
                check("done_seen", exp_q.size(), 0);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.Challenge     = 16'h0000;
        bus.arb_force_en  = 1'b1;
        bus.arb_force_val = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state",
              {bus.busy, bus.done, bus.Response, bus.ones_count, bus.stable, dut.launch_r},
              8'd0);
        check("reset_chain_sel", dut.chain_sel_r, 16'h0000);

        // All ones, challenge changed after acceptance
        run_eval(16'hA5C3, 16'h5A3C, 5'b11111, 1'b1, 1'b1, 3'd5, 1'b1, 0, 0, 1'b0);
        // Reps 0,1,0,1,1 and 1,0,0,1,0
        run_eval(16'h1234, 16'hFFFF, 5'b11010, 1'b1, 1'b1, 3'd3, 1'b0, 0, 0, 1'b0);
        run_eval(16'h8001, 16'h0000, 5'b01001, 1'b1, 1'b0, 3'd2, 1'b0, 0, 0, 1'b0);
        // All zeros, with start at cycle 10 and in the DONE cycle both ignored
        run_eval(16'hFFFF, 16'h0001, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b1, 10, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_requeue", bus.busy, 1'b0);
        end
        // Abort at cycle 20, then a clean evaluation
        run_eval(16'h0F0F, 16'hF0F0, 5'b11111, 1'b1, 1'b1, 3'd5, 1'b1, 0, 20, 1'b0);
        run_eval(16'h0F0F, 16'hF0F0, 5'b10101, 1'b1, 1'b1, 3'd3, 1'b0, 0, 0, 1'b0);
        // Real arbiter path: only timing and self-consistency are known
        run_eval(16'hC3A5, 16'h3C5A, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
